mmio_reg_bridge: RTL

//   Sits between the CCI-P MMIO request channel (rx.c0 MMIO header/data) and the AFU

---
 rtl/mmio_reg_bridge_if.sv | 42 ++++
 rtl/mmio_reg_bridge.sv | 119 +++++++++++
 2 files changed

// File: rtl/mmio_reg_bridge_if.sv
// MMIO request, register bus, MMIO response and status signals of mmio_reg_bridge.
// slave is the bridge's view; master is the view of the surrounding CCI-P/register logic.
interface mmio_reg_bridge_if #(
   parameter int REQ_DEPTH = 16
);
   localparam int CW = $clog2(REQ_DEPTH) + 1;

   logic          mmio_wr_valid;
   logic          mmio_rd_valid;
   logic [15:0]   mmio_addr;
   logic [1:0]    mmio_len;
   logic [8:0]    mmio_tid;
   logic [63:0]   mmio_wdata;
   logic          reg_req_valid;
   logic          reg_req_ready;
   logic          reg_req_wr;
   logic [15:0]   reg_addr;
   logic          reg_len;
   logic [63:0]   reg_wdata;
   logic          reg_rsp_valid;
   logic [63:0]   reg_rsp_data;
   logic          rsp_valid;
   logic [8:0]    rsp_tid;
   logic [63:0]   rsp_data;
   logic [CW-1:0] req_count;
   logic          err_overflow;
   logic          err_protocol;

   modport slave (
      input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
      input  reg_req_ready, reg_rsp_valid, reg_rsp_data,
      output reg_req_valid, reg_req_wr, reg_addr, reg_len, reg_wdata,
      output rsp_valid, rsp_tid, rsp_data, req_count, err_overflow, err_protocol
   );

   modport master (
      output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
      output reg_req_ready, reg_rsp_valid, reg_rsp_data,
      input  reg_req_valid, reg_req_wr, reg_addr, reg_len, reg_wdata,
      input  rsp_valid, rsp_tid, rsp_data, req_count, err_overflow, err_protocol
   );
endinterface

// File: rtl/mmio_reg_bridge.sv
// CCI-P MMIO to in-order valid/ready register bus bridge: request FIFO, read TID
// tracking with an outstanding-read limit, and single-cycle c2 read responses.
module mmio_reg_bridge #(
   parameter int REQ_DEPTH  = 16,
   parameter int MAX_RD_OUT = 4
) (
   input logic             clock,
   input logic             reset,
   mmio_reg_bridge_if.slave bus
);
   localparam int AW = $clog2(REQ_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (MAX_RD_OUT > 1) ? $clog2(MAX_RD_OUT) : 1;
   localparam int OW = $clog2(MAX_RD_OUT) + 1;

   logic          q_wr    [REQ_DEPTH];
   logic [15:0]   q_addr  [REQ_DEPTH];
   logic          q_len   [REQ_DEPTH];
   logic [63:0]   q_wdata [REQ_DEPTH];
   logic [8:0]    q_tid   [REQ_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic [8:0]    t_tid [MAX_RD_OUT];
   logic          t_len [MAX_RD_OUT];
   logic [TW-1:0] t_wr_ptr, t_rd_ptr;
   logic [OW-1:0] outstanding;

   logic          any_valid, len_bad, both, push_req, full, push;
   logic          head_ok, pop, rd_issue, rsp_take, rsp_bad;
   logic [8:0]    pop_tid;
   logic          pop_len;
   logic [63:0]   entry_wdata;
   logic          rsp_valid_q, err_overflow_q, err_protocol_q;
   logic [8:0]    rsp_tid_q;
   logic [63:0]   rsp_data_q;

   always_comb begin
      any_valid   = bus.mmio_wr_valid | bus.mmio_rd_valid;
      len_bad     = bus.mmio_len[1];
      both        = bus.mmio_wr_valid & bus.mmio_rd_valid;
      push_req    = any_valid & ~len_bad;
      full        = (count == CW'(REQ_DEPTH));
      push        = push_req & ~full;
      entry_wdata = '0;
      if (bus.mmio_wr_valid)
         entry_wdata = bus.mmio_len[0] ? bus.mmio_wdata : {32'h0, bus.mmio_wdata[31:0]};
      head_ok  = (count != '0) && (q_wr[rd_ptr] || (outstanding < OW'(MAX_RD_OUT)));
      pop      = head_ok & bus.reg_req_ready;
      rd_issue = pop & ~q_wr[rd_ptr];
      // A response arriving while the only pending read is being issued pairs with that read.
      rsp_take = bus.reg_rsp_valid & ((outstanding != '0) | rd_issue);
      rsp_bad  = bus.reg_rsp_valid & ~rsp_take;
      if (outstanding == '0) begin
         pop_tid = q_tid[rd_ptr];
         pop_len = q_len[rd_ptr];
      end else begin
         pop_tid = t_tid[t_rd_ptr];
         pop_len = t_len[t_rd_ptr];
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_wr[wr_ptr]    <= bus.mmio_wr_valid;
         q_addr[wr_ptr]  <= bus.mmio_addr;
         q_len[wr_ptr]   <= bus.mmio_len[0];
         q_wdata[wr_ptr] <= entry_wdata;
         q_tid[wr_ptr]   <= bus.mmio_tid;
      end
      if (rd_issue) begin
         t_tid[t_wr_ptr] <= q_tid[rd_ptr];
         t_len[t_wr_ptr] <= q_len[rd_ptr];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         t_wr_ptr       <= '0;
         t_rd_ptr       <= '0;
         outstanding    <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_tid_q      <= '0;
         rsp_data_q     <= '0;
         err_overflow_q <= 1'b0;
         err_protocol_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (rd_issue)
            t_wr_ptr <= (t_wr_ptr == TW'(MAX_RD_OUT - 1)) ? '0 : t_wr_ptr + 1'b1;
         if (rsp_take)
            t_rd_ptr <= (t_rd_ptr == TW'(MAX_RD_OUT - 1)) ? '0 : t_rd_ptr + 1'b1;
         outstanding    <= outstanding + OW'(rd_issue) - OW'(rsp_take);
         rsp_valid_q    <= rsp_take;
         rsp_tid_q      <= rsp_take ? pop_tid : '0;
         rsp_data_q     <= !rsp_take ? '0 :
                           pop_len ? bus.reg_rsp_data : {32'h0, bus.reg_rsp_data[31:0]};
         err_overflow_q <= err_overflow_q | (push_req & full);
         err_protocol_q <= err_protocol_q | both | (any_valid & len_bad) | rsp_bad;
      end
   end

   assign bus.reg_req_valid = head_ok;
   assign bus.reg_req_wr    = head_ok & q_wr[rd_ptr];
   assign bus.reg_addr      = head_ok ? q_addr[rd_ptr] : '0;
   assign bus.reg_len       = head_ok & q_len[rd_ptr];
   assign bus.reg_wdata     = head_ok ? q_wdata[rd_ptr] : '0;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_tid       = rsp_tid_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.req_count     = count;
   assign bus.err_overflow  = err_overflow_q;
   assign bus.err_protocol  = err_protocol_q;
endmodule
